// File: rtl/antirrebote_botones.sv
`default_nettype none
// ============================================================================
//  Module      : antirrebote_botones
//  Description : Two-channel push-button conditioner. Each raw, active-low
//                button line is synchronised to clk with two flops and then
//                filtered by a stability counter. Each channel produces a
//                clean active-low level and a one-cycle press strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module antirrebote_botones #(
    parameter int STABLE_CYCLES = 250000,
    parameter int CNT_W         = 18
) (
    input  logic clk,
    input  logic reset,
    input  logic sum_raw,
    input  logic res_raw,
    output logic sum,
    output logic res,
    output logic sum_press,
    output logic res_press
);

    // Terminal count: a candidate level is accepted on the cycle the counter
    // already holds STABLE_CYCLES-1 and the new level is still present.
    localparam logic [CNT_W-1:0] c_last_count = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_REL   = 2'd0,   // stable released, level = 1
        ST_CHK_P = 2'd1,   // candidate press being timed
        ST_PRS   = 2'd2,   // stable pressed, level = 0
        ST_CHK_R = 2'd3    // candidate release being timed
    } state_t;

    // Channel 0 = sum, channel 1 = res.
    logic [1:0] w_raw;
    logic [1:0] w_level;
    logic [1:0] w_strobe;

    assign w_raw = {res_raw, sum_raw};

    generate
        for (genvar g = 0; g < 2; g++) begin : g_chan
            logic             r_s1;
            logic             r_s2;
            state_t           r_state;
            logic [CNT_W-1:0] r_cnt;
            logic             r_level;
            logic             r_strobe;

            // Two-flop synchroniser; only r_s2 is safe to use downstream.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_s1 <= 1'b1;
                    r_s2 <= 1'b1;
                end else begin
                    r_s1 <= w_raw[g];
                    r_s2 <= r_s1;
                end
            end

            // Debounce FSM: any return to the stable level restarts the count.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_state  <= ST_REL;
                    r_cnt    <= '0;
                    r_level  <= 1'b1;
                    r_strobe <= 1'b0;
                end else begin
                    r_strobe <= 1'b0;
                    case (r_state)
                        ST_REL: begin
                            if (!r_s2) begin
                                r_state <= ST_CHK_P;
                                r_cnt   <= CNT_W'(1);
                            end
                        end
                        ST_CHK_P: begin
                            if (r_s2) begin
                                r_state <= ST_REL;
                                r_cnt   <= '0;
                            end else if (r_cnt == c_last_count) begin
                                r_state  <= ST_PRS;
                                r_level  <= 1'b0;
                                r_strobe <= 1'b1;
                                r_cnt    <= '0;
                            end else begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end
                        end
                        ST_PRS: begin
                            if (r_s2) begin
                                r_state <= ST_CHK_R;
                                r_cnt   <= CNT_W'(1);
                            end
                        end
                        ST_CHK_R: begin
                            if (!r_s2) begin
                                r_state <= ST_PRS;
                                r_cnt   <= '0;
                            end else if (r_cnt == c_last_count) begin
                                r_state <= ST_REL;
                                r_level <= 1'b1;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end
                        end
                        default: begin
                            r_state <= ST_REL;
                            r_cnt   <= '0;
                            r_level <= 1'b1;
                        end
                    endcase
                end
            end

            assign w_level[g]  = r_level;
            assign w_strobe[g] = r_strobe;
        end
    endgenerate

    assign sum       = w_level[0];
    assign res       = w_level[1];
    assign sum_press = w_strobe[0];
    assign res_press = w_strobe[1];

endmodule
`default_nettype wire
